// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: frame-synchronous value loading,
// one shared decoder, active-low anodes. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  digit_code,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend_val;
  logic          restart;

  logic          tick;
  logic          boundary;
  logic          xfer;
  logic [15:0]   disp_next;
  logic [1:0]    idx_next;
  logic [3:0]    code_next;

  function automatic logic [3:0] pick(input logic [15:0] d, input logic [1:0] i);
    logic [3:0] nib;
`ifdef SEG_LZB_EN
    logic       blank;
`endif
    nib = d[{i, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    // A digit is blanked only when it and every digit to its left are zero.
    case (i)
      2'd3:    blank = (d[15:12] == 4'h0);
      2'd2:    blank = (d[15:8] == 8'h00);
      2'd1:    blank = (d[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    if (blank) nib = 4'hF;
`endif
    return nib;
  endfunction

  always_comb begin
    tick      = en && (cnt == CW'(PRESCALE - 1));
    boundary  = tick && (idx == 2'd3);
    // Disabling the scan is also a safe moment to apply a waiting value.
    xfer      = pending && (boundary || !en);
    disp_next = xfer ? pend_val : disp;
    // After a disable the first tick shows digit 0 instead of advancing.
    idx_next  = restart ? 2'd0 : idx + 2'd1;
    code_next = pick(disp_next, idx_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= 16'hFFFF;
      pend_val   <= 16'h0000;
      pending    <= 1'b0;
      restart    <= 1'b0;
      frame_done <= 1'b0;
      an         <= 4'b1111;
      digit_code <= 4'hF;
    end else begin
      frame_done <= boundary;
      if (xfer) disp <= pend_val;
      // A load in the transfer cycle refills the pending slot.
      if (load) begin
        pend_val <= value;
        pending  <= 1'b1;
      end else if (xfer) begin
        pending  <= 1'b0;
      end
      if (!en) begin
        cnt        <= '0;
        idx        <= 2'd0;
        restart    <= 1'b1;
        an         <= 4'b1111;
        digit_code <= 4'hF;
      end else begin
        cnt <= tick ? '0 : cnt + CW'(1);
        if (tick) begin
          idx        <= idx_next;
          restart    <= 1'b0;
          an         <= ~(4'b0001 << idx_next);
          digit_code <= code_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=4; expectations are hand-derived
// edge by edge. Define SEG_LZB_EN to check the blanking build.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_code;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int checks;
  int passes;

`ifdef SEG_LZB_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  seg_scan_ctrl #(.PRESCALE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .digit_code (digit_code),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_an, input logic [3:0] exp_code);
    check({tag, "_an"}, {12'h0, an}, {12'h0, exp_an});
    check({tag, "_code"}, {12'h0, digit_code}, {12'h0, exp_code});
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    load   = 1'b0;
    value  = 16'h0000;

    // reset state
    cycles(2);
    check_out("reset", 4'b1111, 4'hF);
    check("reset_pending", {15'h0, pending}, 16'h0);
    check("reset_fd", {15'h0, frame_done}, 16'h0);

    // first tick after release shows digit 1, still blank
    rst_n = 1'b1;
    cycles(3);
    check_out("pre_tick", 4'b1111, 4'hF);
    cycles(1);
    check_out("first_tick", 4'b1101, 4'hF);

    // load 0x1234, applied at the next boundary
    load = 1'b1; value = 16'h1234;
    cycles(1);
    load = 1'b0;
    check("load_pending", {15'h0, pending}, 16'h1);
    cycles(3);
    check_out("old_d2", 4'b1011, 4'hF);
    cycles(8);
    check_out("scan_d0", 4'b1110, 4'h4);
    check("xfer_pending", {15'h0, pending}, 16'h0);
    check("fd_pulse1", {15'h0, frame_done}, 16'h1);
    cycles(1);
    check("fd_low", {15'h0, frame_done}, 16'h0);
    check_out("hold_d0", 4'b1110, 4'h4);
    cycles(3);
    check_out("scan_d1", 4'b1101, 4'h3);

    // tear-free load mid-frame
    cycles(1);
    load = 1'b1; value = 16'h5678;
    cycles(1);
    load = 1'b0;
    check("tear_pending", {15'h0, pending}, 16'h1);
    check_out("tear_hold_d1", 4'b1101, 4'h3);
    cycles(2);
    check_out("tear_d2", 4'b1011, 4'h2);
    cycles(4);
    check_out("tear_d3", 4'b0111, 4'h1);
    check("tear_pending_d3", {15'h0, pending}, 16'h1);
    cycles(4);
    check_out("new_d0", 4'b1110, 4'h8);
    check("new_pending", {15'h0, pending}, 16'h0);
    check("fd_pulse2", {15'h0, frame_done}, 16'h1);
    cycles(4);
    check_out("new_d1", 4'b1101, 4'h7);
    cycles(4);
    check_out("new_d2", 4'b1011, 4'h6);
    cycles(4);
    check_out("new_d3", 4'b0111, 4'h5);

    // load 0x9999 in the boundary cycle while 0x1111 waits
    load = 1'b1; value = 16'h1111;
    cycles(1);
    load = 1'b0;
    cycles(2);
    load = 1'b1; value = 16'h9999;
    cycles(1);
    load = 1'b0;
    check_out("bnd_d0", 4'b1110, 4'h1);
    check("bnd_pending", {15'h0, pending}, 16'h1);
    check("bnd_fd", {15'h0, frame_done}, 16'h1);
    cycles(4);
    check_out("bnd_d1", 4'b1101, 4'h1);
    cycles(12);
    check_out("bnd_next", 4'b1110, 4'h9);
    check("bnd_next_pending", {15'h0, pending}, 16'h0);

    // disable with a pending value, then re-enable
    cycles(1);
    load = 1'b1; value = 16'h0042;
    cycles(1);
    load = 1'b0;
    check("dis_pending_pre", {15'h0, pending}, 16'h1);
    en = 1'b0;
    cycles(1);
    check_out("dis_blank", 4'b1111, 4'hF);
    check("dis_xfer", {15'h0, pending}, 16'h0);
    check("dis_fd", {15'h0, frame_done}, 16'h0);
    cycles(3);
    check_out("dis_hold", 4'b1111, 4'hF);
    en = 1'b1;
    cycles(3);
    check_out("reen_wait", 4'b1111, 4'hF);
    cycles(1);
    check_out("reen_d0", 4'b1110, 4'h2);
    cycles(4);
    check_out("reen_d1", 4'b1101, 4'h4);
    cycles(4);
    check_out("lz_d2", 4'b1011, LZ);
    cycles(4);
    check_out("lz_d3", 4'b0111, LZ);
    cycles(4);
    check_out("reen_wrap", 4'b1110, 4'h2);
    check("reen_fd", {15'h0, frame_done}, 16'h1);

    // all-zero value: digit 0 is never blanked
    cycles(1);
    load = 1'b1; value = 16'h0000;
    cycles(1);
    load = 1'b0;
    cycles(14);
    check_out("zero_d0", 4'b1110, 4'h0);
    cycles(4);
    check_out("zero_d1", 4'b1101, LZ);

    // reset while a value is pending discards it
    load = 1'b1; value = 16'hABCD;
    cycles(1);
    load = 1'b0;
    check("rst_pend_pre", {15'h0, pending}, 16'h1);
    rst_n = 1'b0;
    #2;
    check_out("rst_mid", 4'b1111, 4'hF);
    check("rst_mid_pending", {15'h0, pending}, 16'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    check_out("rst_after", 4'b1101, 4'hF);
    check("rst_after_pending", {15'h0, pending}, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
